// File: rtl/sna_request_sequencer.sv
// SNA request flow: assembles header/address/data flits into one
// AXI4-Lite transaction and hands its completion to the response flow.
module sna_request_sequencer #(
    parameter int FLIT_W = 37,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] noc_data,
    input  logic              noc_valid,
    output logic              noc_ready,
    output logic [DATA_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [DATA_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_read,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic [3:0]        rsp_pov_addr,
    output logic              drop_err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_ADDR, WAIT_DATA, AR, R, AW_W, B, RESP
    } state_t;

    localparam logic [1:0] T_ADDR = 2'b00;
    localparam logic [1:0] T_DATA = 2'b01;
    localparam logic [1:0] T_HDR  = 2'b10;

    state_t            state, state_n;
    logic              req_read;
    logic [3:0]        req_pov;
    logic [DATA_W-1:0] req_addr, req_data;
    logic              flit_acc;
    logic [1:0]        flit_type;
    logic              hdr_ld, addr_ld, data_ld, drop;
    logic              aw_ok, w_ok;
    logic              unused_bits;

    assign unused_bits = ^noc_data[FLIT_W-3:DATA_W];

    // Held low while reset is asserted so no flit is taken during reset.
    assign noc_ready = rst_n &&
                       (state == IDLE || state == WAIT_ADDR ||
                        state == WAIT_DATA);
    assign flit_acc  = noc_valid && noc_ready;
    assign flit_type = noc_data[FLIT_W-1 -: 2];

    assign awaddr = req_addr;
    assign araddr = req_addr;
    assign wdata  = req_data;
    assign wstrb  = 4'hF;

    assign aw_ok = !awvalid || awready;
    assign w_ok  = !wvalid || wready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        hdr_ld  = 1'b0;
        addr_ld = 1'b0;
        data_ld = 1'b0;
        drop    = 1'b0;
        unique case (state)
            IDLE: if (flit_acc) begin
                if (flit_type == T_HDR) begin
                    hdr_ld  = 1'b1;
                    state_n = WAIT_ADDR;
                end else begin
                    drop = 1'b1;
                end
            end
            WAIT_ADDR: if (flit_acc) begin
                if (flit_type == T_HDR) begin
                    hdr_ld = 1'b1;
                end else if (flit_type == T_ADDR) begin
                    addr_ld = 1'b1;
                    state_n = req_read ? AR : WAIT_DATA;
                end else begin
                    drop    = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_DATA: if (flit_acc) begin
                if (flit_type == T_HDR) begin
                    hdr_ld  = 1'b1;
                    state_n = WAIT_ADDR;
                end else if (flit_type == T_DATA) begin
                    data_ld = 1'b1;
                    state_n = AW_W;
                end else begin
                    drop    = 1'b1;
                    state_n = IDLE;
                end
            end
            AR:   if (arvalid && arready) state_n = R;
            R:    if (rvalid && rready) state_n = RESP;
            AW_W: if (aw_ok && w_ok) state_n = B;
            B:    if (bvalid && bready) state_n = RESP;
            RESP: if (rsp_valid && rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_read     <= 1'b0;
            req_pov      <= '0;
            req_addr     <= '0;
            req_data     <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_read     <= 1'b0;
            rsp_data     <= '0;
            rsp_resp     <= '0;
            rsp_pov_addr <= '0;
            drop_err     <= 1'b0;
        end else begin
            drop_err  <= drop;
            arvalid   <= (state_n == AR);
            rready    <= (state_n == R);
            bready    <= (state_n == B);
            rsp_valid <= (state_n == RESP);
            if (hdr_ld) begin
                req_read <= noc_data[0];
                req_pov  <= noc_data[27:24];
            end
            if (addr_ld) req_addr <= noc_data[DATA_W-1:0];
            if (data_ld) req_data <= noc_data[DATA_W-1:0];
            // Both write channels open together, then close independently.
            if (state != AW_W && state_n == AW_W) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
            end else begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
            end
            if (rvalid && rready) begin
                rsp_read     <= 1'b1;
                rsp_data     <= rdata;
                rsp_resp     <= rresp;
                rsp_pov_addr <= req_pov;
            end
            if (bvalid && bready) begin
                rsp_read     <= 1'b0;
                rsp_data     <= '0;
                rsp_resp     <= bresp;
                rsp_pov_addr <= req_pov;
            end
        end
    end

endmodule

// File: tb/tb_sna_request_sequencer.sv
// Bench for sna_request_sequencer: flit-level model plus AXI slave,
// checked every cycle, with directed vectors pinning key values.
module tb_sna_request_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [36:0] noc_data = '0;
    logic        noc_valid = 1'b0;
    logic        noc_ready;
    logic [31:0] awaddr, wdata, araddr, rsp_data;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  wstrb, rsp_pov_addr;
    logic        awready = 1'b0, wready = 1'b0;
    logic        bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0, rsp_resp;
    logic [31:0] rdata = '0;
    logic        rsp_valid, rsp_read, drop_err;
    logic        rsp_ready = 1'b1;

    always #5 clk = ~clk;

    sna_request_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .noc_data(noc_data), .noc_valid(noc_valid), .noc_ready(noc_ready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_read(rsp_read), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .rsp_pov_addr(rsp_pov_addr), .drop_err(drop_err)
    );

    int checks = 0;
    int errors = 0;
    int drop_pulses = 0;
    int ar_cnt = 0;
    int aw_cnt = 0;

    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = '0, bresp_cfg = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] mk_hdr(input logic rd,
                                           input logic [3:0] pov);
        return {2'b10, 7'd0, pov, 23'd0, rd};
    endfunction
    function automatic logic [36:0] mk_addr(input logic [31:0] a);
        return {2'b00, 3'd0, a};
    endfunction
    function automatic logic [36:0] mk_data(input logic [31:0] d);
        return {2'b01, 3'd0, d};
    endfunction

    // Edge-time events, consumed by the slave and the model at negedge.
    logic        cap_rst = 1'b0, cap_acc = 1'b0;
    logic        cap_ar = 1'b0, cap_r = 1'b0, cap_aw = 1'b0;
    logic        cap_w = 1'b0, cap_b = 1'b0, cap_rsp = 1'b0;
    logic [36:0] cap_flit = '0;

    always @(posedge clk) begin
        cap_rst  <= !rst_n;
        cap_acc  <= rst_n && noc_valid && noc_ready;
        cap_flit <= noc_data;
        cap_ar   <= rst_n && arvalid && arready;
        cap_r    <= rst_n && rvalid && rready;
        cap_aw   <= rst_n && awvalid && awready;
        cap_w    <= rst_n && wvalid && wready;
        cap_b    <= rst_n && bvalid && bready;
        cap_rsp  <= rst_n && rsp_valid && rsp_ready;
    end

    // AXI4-Lite slave with per-channel wait states.
    initial begin
        int arw, aww, ww, rw, bw;
        bit rp, bp, awd, wd;
        arw = 0; aww = 0; ww = 0; rw = 0; bw = 0;
        rp = 0; bp = 0; awd = 0; wd = 0;
        forever begin
            @(negedge clk);
            if (cap_rst || !rst_n) begin
                arready = 0; awready = 0; wready = 0;
                rvalid = 0; bvalid = 0;
                arw = 0; aww = 0; ww = 0; rw = 0; bw = 0;
                rp = 0; bp = 0; awd = 0; wd = 0;
            end else begin
                if (cap_r) rvalid = 0;
                if (cap_b) bvalid = 0;
                if (cap_ar) begin rp = 1; rw = 0; end
                if (cap_aw) awd = 1;
                if (cap_w)  wd = 1;
                if (awd && wd) begin
                    bp = 1; bw = 0; awd = 0; wd = 0;
                end
                if (arvalid) begin arready = (arw >= ar_dly); arw++; end
                else begin arready = 0; arw = 0; end
                if (awvalid) begin awready = (aww >= aw_dly); aww++; end
                else begin awready = 0; aww = 0; end
                if (wvalid) begin wready = (ww >= w_dly); ww++; end
                else begin wready = 0; ww = 0; end
                if (rp) begin
                    if (rw >= r_dly) begin
                        rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg;
                        rp = 0;
                    end else rw++;
                end
                if (bp) begin
                    if (bw >= b_dly) begin
                        bvalid = 1; bresp = bresp_cfg; bp = 0;
                    end else bw++;
                end
            end
        end
    end

    // Request-level model: turns the accepted flit stream into expected
    // AXI requests, completions and drops, then checks every cycle.
    initial begin
        int          phase;  // 0 idle, 1 need addr, 2 need data, 3 busy
        logic        hr;
        logic [3:0]  hp;
        logic [31:0] ma;
        logic [1:0]  typ;
        logic [31:0] arq[$];
        logic [63:0] wq[$];
        logic [38:0] rq[$];
        bit          awd, wd, exp_drop, p_ar, p_aw, p_w;
        phase = 0; hr = 0; hp = 0; ma = 0;
        awd = 0; wd = 0; p_ar = 0; p_aw = 0; p_w = 0;
        forever begin
            @(negedge clk);
            exp_drop = 0;
            if (cap_rst) begin
                phase = 0;
                arq.delete(); wq.delete(); rq.delete();
                awd = 0; wd = 0;
                check("reset_outputs",
                      {arvalid, awvalid, wvalid, bready, rready, rsp_valid,
                       drop_err, rsp_read, rsp_resp, rsp_pov_addr},
                      14'd0);
                check("reset_rsp_data", rsp_data, 0);
                check("reset_noc_ready", noc_ready, rst_n);
                p_ar = 0; p_aw = 0; p_w = 0;
            end else begin
                if (cap_ar) begin
                    ar_cnt++;
                    check("ar_hs_expected", arq.size() != 0, 1);
                    if (arq.size() != 0) void'(arq.pop_front());
                end
                if (cap_aw) begin awd = 1; aw_cnt++; end
                if (cap_w)  wd = 1;
                if (awd && wd) begin
                    check("w_hs_expected", wq.size() != 0, 1);
                    if (wq.size() != 0) void'(wq.pop_front());
                    awd = 0; wd = 0;
                end
                if (cap_rsp) begin
                    check("rsp_hs_expected", rq.size() != 0, 1);
                    if (rq.size() != 0) void'(rq.pop_front());
                    phase = 0;
                end
                if (cap_acc) begin
                    typ = cap_flit[36:35];
                    case (phase)
                        0: if (typ == 2'b10) begin
                            hr = cap_flit[0]; hp = cap_flit[27:24];
                            phase = 1;
                        end else exp_drop = 1;
                        1: if (typ == 2'b10) begin
                            hr = cap_flit[0]; hp = cap_flit[27:24];
                        end else if (typ == 2'b00) begin
                            ma = cap_flit[31:0];
                            if (hr) begin
                                arq.push_back(ma);
                                rq.push_back({1'b1, rdata_cfg, rresp_cfg, hp});
                                phase = 3;
                            end else phase = 2;
                        end else begin
                            exp_drop = 1; phase = 0;
                        end
                        2: if (typ == 2'b10) begin
                            hr = cap_flit[0]; hp = cap_flit[27:24];
                            phase = 1;
                        end else if (typ == 2'b01) begin
                            wq.push_back({ma, cap_flit[31:0]});
                            rq.push_back({1'b0, 32'h0, bresp_cfg, hp});
                            phase = 3;
                        end else begin
                            exp_drop = 1; phase = 0;
                        end
                        default: ;
                    endcase
                end
                if (drop_err) drop_pulses++;
                check("drop_err", drop_err, exp_drop);
                check("noc_ready", noc_ready, rst_n && phase != 3);
                if (arvalid) begin
                    check("arvalid_expected", arq.size() != 0, 1);
                    if (arq.size() != 0) check("araddr", araddr, arq[0]);
                end
                if (awvalid) begin
                    check("awvalid_after_hs", awd, 0);
                    check("awvalid_expected", wq.size() != 0, 1);
                    if (wq.size() != 0) check("awaddr", awaddr, wq[0][63:32]);
                end
                if (wvalid) begin
                    check("wvalid_after_hs", wd, 0);
                    check("wstrb", wstrb, 4'hF);
                    check("wvalid_expected", wq.size() != 0, 1);
                    if (wq.size() != 0) check("wdata", wdata, wq[0][31:0]);
                end
                if (rsp_valid) begin
                    check("rsp_expected", rq.size() != 0, 1);
                    if (rq.size() != 0)
                        check("rsp_fields",
                              {rsp_read, rsp_data, rsp_resp, rsp_pov_addr},
                              rq[0]);
                end
                if (p_ar && !cap_ar) check("arvalid_held", arvalid, 1);
                if (p_aw && !cap_aw) check("awvalid_held", awvalid, 1);
                if (p_w && !cap_w)   check("wvalid_held", wvalid, 1);
                p_ar = arvalid; p_aw = awvalid; p_w = wvalid;
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_flit(input logic [36:0] f);
        int n;
        n = 0;
        noc_data  = f;
        noc_valid = 1'b1;
        @(negedge clk);
        while (!noc_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("flit_accepted", noc_ready, 1);
        @(posedge clk);
        #1 noc_valid = 1'b0;
    endtask

    // Counts negedges until rsp_valid is seen, bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_within_bound", rsp_valid, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, d0, ar0, aw0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("noc_ready_in_reset", noc_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("noc_ready_after_reset", noc_ready, 1);
        @(posedge clk);
        #1;

        // Read with zero-wait slave.
        rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
        send_flit(mk_hdr(1'b1, 4'd3));
        send_flit(mk_addr(32'h10000040));
        @(negedge clk);
        check("read_arvalid", arvalid, 1);
        check("read_araddr", araddr, 32'h10000040);
        wait_rsp(n);
        check("read_latency", n, 2);
        check("read_rsp", {rsp_read, rsp_data, rsp_resp, rsp_pov_addr},
              {1'b1, 32'hDEADBEEF, 2'b00, 4'd3});
        @(posedge clk);
        #1;

        // Write with wready three cycles after awready.
        w_dly = 3; bresp_cfg = 2'b10;
        send_flit(mk_hdr(1'b0, 4'd5));
        send_flit(mk_addr(32'h20));
        send_flit(mk_data(32'hCAFE0001));
        @(negedge clk);
        check("write_valids_start", {awvalid, wvalid}, 2'b11);
        check("write_awaddr", awaddr, 32'h20);
        check("write_wdata", wdata, 32'hCAFE0001);
        @(negedge clk);
        check("write_aw_first", {awvalid, wvalid}, 2'b01);
        wait_rsp(n);
        check("write_rsp", {rsp_read, rsp_data, rsp_resp, rsp_pov_addr},
              {1'b0, 32'h0, 2'b10, 4'd5});
        @(posedge clk);
        #1;

        // Out-of-order flits in IDLE.
        d0 = drop_pulses; ar0 = ar_cnt; aw0 = aw_cnt;
        send_flit(mk_data(32'h1));
        send_flit({2'b11, 35'h0});
        repeat (2) @(posedge clk);
        #1;
        check("ooo_drops", drop_pulses - d0, 2);
        check("ooo_no_ar", ar_cnt - ar0, 0);
        check("ooo_no_aw", aw_cnt - aw0, 0);
        check("ooo_idle", noc_ready, 1);

        // Header restart.
        rdata_cfg = 32'h12345678; rresp_cfg = 2'b01;
        d0 = drop_pulses; ar0 = ar_cnt;
        send_flit(mk_hdr(1'b1, 4'd1));
        send_flit(mk_hdr(1'b1, 4'd7));
        send_flit(mk_addr(32'h44));
        wait_rsp(n);
        check("restart_rsp", {rsp_read, rsp_data, rsp_resp, rsp_pov_addr},
              {1'b1, 32'h12345678, 2'b01, 4'd7});
        check("restart_single_ar", ar_cnt - ar0, 1);
        check("restart_no_drop", drop_pulses - d0, 0);
        @(posedge clk);
        #1;

        // Completion back-pressure.
        rsp_ready = 1'b0;
        rdata_cfg = 32'hA5A50F0F; rresp_cfg = 2'b00;
        send_flit(mk_hdr(1'b1, 4'd9));
        send_flit(mk_addr(32'h80));
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp", {rsp_valid, rsp_read, rsp_data, rsp_resp,
                             rsp_pov_addr, noc_ready},
                  {1'b1, 1'b1, 32'hA5A50F0F, 2'b00, 4'd9, 1'b0});
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        noc_data  = mk_hdr(1'b1, 4'd2);
        noc_valid = 1'b1;
        @(negedge clk);
        check("bp_not_ready_in_resp", noc_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_next_cycle", noc_ready, 1);
        @(posedge clk);
        #1 noc_valid = 1'b0;
        send_flit(mk_addr(32'h84));
        wait_rsp(n);
        check("bp_next_pov", rsp_pov_addr, 4'd2);
        @(posedge clk);
        #1;

        // Reset while waiting for arready.
        ar_dly = 50;
        send_flit(mk_hdr(1'b1, 4'd4));
        send_flit(mk_addr(32'h100));
        @(negedge clk);
        check("rst_mid_arvalid", arvalid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_outputs", {arvalid, noc_ready, rsp_valid}, 3'b000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ar_dly = 0;
        @(negedge clk);
        check("rst_mid_ready", noc_ready, 1);
        @(posedge clk);
        #1;
        rdata_cfg = 32'h0BADF00D;
        send_flit(mk_hdr(1'b1, 4'd6));
        send_flit(mk_addr(32'h200));
        @(negedge clk);
        check("rst_mid_araddr", araddr, 32'h200);
        wait_rsp(n);
        check("rst_mid_rsp", {rsp_read, rsp_data, rsp_resp, rsp_pov_addr},
              {1'b1, 32'h0BADF00D, 2'b00, 4'd6});
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
